// File: rtl/sample_feeder_pkg.sv
// ============================================================================
// sample_feeder_pkg : shared FSM encoding and field widths for sample_feeder
// Rev 1.0
// ============================================================================
`default_nettype none

package sample_feeder_pkg;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_WAIT = 2'd1,
      ST_PLAY = 2'd2
   } state_t;

   localparam int c_X_W     = 7;
   localparam int c_T_W     = 2;
   localparam int c_SMP_W   = 2 * c_X_W + c_T_W;
   localparam int c_EPOCH_W = 16;

endpackage

`default_nettype wire

// File: rtl/sample_feeder_ram.sv
// ============================================================================
// sample_ram : DEPTH x sample-word storage, registered write, async read
// Rev 1.0
// ============================================================================
`default_nettype none

module sample_ram
   import sample_feeder_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               i_we,
   input  logic [AW-1:0]      i_waddr,
   input  logic [c_SMP_W-1:0] i_wdata,
   input  logic [AW-1:0]      i_raddr,
   output logic [c_SMP_W-1:0] o_rdata
);

   // No reset on storage: contents are only visible after being rewritten.
   logic [c_SMP_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/sample_feeder.sv
// ============================================================================
// sample_feeder : loads training samples, then replays them once per epoch
// Rev 1.0
// ============================================================================
`default_nettype none

module sample_feeder
   import sample_feeder_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wrValid,
   output logic                        wrReady,
   input  logic signed [c_X_W-1:0]     wrX1,
   input  logic signed [c_X_W-1:0]     wrX2,
   input  logic signed [c_T_W-1:0]     wrT,
   input  logic                        loadDone,
   input  logic                        start,
   input  logic                        clear,
   output logic                        smpValid,
   input  logic                        smpReady,
   output logic signed [c_X_W-1:0]     x1,
   output logic signed [c_X_W-1:0]     x2,
   output logic signed [c_T_W-1:0]     t,
   output logic [31:0]                 sampleCount,
   output logic                        epochEnd,
   output logic [c_EPOCH_W-1:0]        epochCount
);

   localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);

   state_t                 r_state;
   logic [AW:0]            r_count;
   logic [AW-1:0]          r_rdPtr;
   logic [c_EPOCH_W-1:0]   r_epochCount;
   logic                   r_epochEnd;

   logic                   w_wrReady;
   logic                   w_wr;
   logic                   w_play;
   logic                   w_last;
   logic [c_SMP_W-1:0]     w_rdata;

   assign w_wrReady = (r_state == ST_LOAD) && (r_count < c_FULL);
   // Writes are suppressed by clear/rst so they cannot beat the count reset.
   assign w_wr      = w_wrReady && wrValid && !clear && !rst;
   assign w_play    = (r_state == ST_PLAY);
   assign w_last    = ({1'b0, r_rdPtr} == (r_count - 1'b1));

   sample_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_wr),
      .i_waddr (r_count[AW-1:0]),
      .i_wdata ({wrX1, wrX2, wrT}),
      .i_raddr (r_rdPtr),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_LOAD;
         r_count      <= '0;
         r_rdPtr      <= '0;
         r_epochCount <= '0;
         r_epochEnd   <= 1'b0;
      end else begin
         r_epochEnd <= 1'b0;
         if (clear) begin
            r_state      <= ST_LOAD;
            r_count      <= '0;
            r_rdPtr      <= '0;
            r_epochCount <= '0;
         end else begin
            case (r_state)
               ST_LOAD: begin
                  if (w_wr) begin
                     r_count <= r_count + 1'b1;
                  end
                  if (loadDone && ((r_count != '0) || w_wr)) begin
                     r_state <= ST_WAIT;
                  end
               end
               ST_WAIT: begin
                  if (start) begin
                     r_rdPtr <= '0;
                     r_state <= ST_PLAY;
                  end
               end
               ST_PLAY: begin
                  if (smpReady) begin
                     if (w_last) begin
                        r_state    <= ST_WAIT;
                        r_epochEnd <= 1'b1;
                        if (r_epochCount != '1) begin
                           r_epochCount <= r_epochCount + 1'b1;
                        end
                     end else begin
                        r_rdPtr <= r_rdPtr + 1'b1;
                     end
                  end
               end
               default: r_state <= ST_LOAD;
            endcase
         end
      end
   end

   assign wrReady     = w_wrReady;
   assign smpValid    = w_play;
   assign x1          = w_play ? w_rdata[c_SMP_W-1 -: c_X_W]       : '0;
   assign x2          = w_play ? w_rdata[c_T_W+c_X_W-1 -: c_X_W]   : '0;
   assign t           = w_play ? w_rdata[c_T_W-1:0]                : '0;
   assign sampleCount = 32'(r_count);
   assign epochEnd    = r_epochEnd;
   assign epochCount  = r_epochCount;

endmodule

`default_nettype wire

// File: tb/tb_sample_feeder.sv
// ============================================================================
// tb_sample_feeder : directed self-checking bench for sample_feeder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sample_feeder;

   localparam int DEPTH = 8;

   logic              clk = 1'b0;
   logic              rst, wrValid, loadDone, start, clear, smpReady;
   logic signed [6:0] wrX1, wrX2;
   logic signed [1:0] wrT;
   logic              wrReady, smpValid, epochEnd;
   logic signed [6:0] x1, x2;
   logic signed [1:0] t;
   logic [31:0]       sampleCount;
   logic [15:0]       epochCount;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sample_feeder #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .wrValid     (wrValid),
      .wrReady     (wrReady),
      .wrX1        (wrX1),
      .wrX2        (wrX2),
      .wrT         (wrT),
      .loadDone    (loadDone),
      .start       (start),
      .clear       (clear),
      .smpValid    (smpValid),
      .smpReady    (smpReady),
      .x1          (x1),
      .x2          (x2),
      .t           (t),
      .sampleCount (sampleCount),
      .epochEnd    (epochEnd),
      .epochCount  (epochCount)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] smp(input logic signed [6:0] a, input logic signed [6:0] b,
                                       input logic signed [1:0] c);
      return {16'd0, a, b, c};
   endfunction

   task automatic wr(input logic signed [6:0] a, input logic signed [6:0] b, input logic signed [1:0] c);
      wrValid = 1'b1; wrX1 = a; wrX2 = b; wrT = c;
      step();
      wrValid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; wrValid = 0; loadDone = 0; start = 0; clear = 0; smpReady = 0;
      wrX1 = 0; wrX2 = 0; wrT = 0;
      step(); step();
      rst = 1'b0;
      chk("rst_wrReady", 32'(wrReady), 32'd1);
      chk("rst_smpValid", 32'(smpValid), 32'd0);
      chk("rst_data", smp(x1, x2, t), 32'd0);
      chk("rst_count", sampleCount, 32'd0);
      chk("rst_epochEnd", 32'(epochEnd), 32'd0);
      chk("rst_epochCount", 32'(epochCount), 32'd0);

      // Basic three-sample epoch
      wr(7'sd5, -7'sd3, 2'sd1);
      wr(-7'sd7, 7'sd2, -2'sd1);
      wr(7'sd0, 7'sd4, 2'sd1);
      loadDone = 1'b1; step(); loadDone = 1'b0;
      chk("wait_wrReady", 32'(wrReady), 32'd0);
      chk("wait_smpValid", 32'(smpValid), 32'd0);
      smpReady = 1'b1;
      start = 1'b1; step(); start = 1'b0;
      chk("e1_v0", 32'(smpValid), 32'd1);
      chk("e1_s0", smp(x1, x2, t), smp(7'sd5, -7'sd3, 2'sd1));
      step();
      chk("e1_v1", 32'(smpValid), 32'd1);
      chk("e1_s1", smp(x1, x2, t), smp(-7'sd7, 7'sd2, -2'sd1));
      step();
      chk("e1_v2", 32'(smpValid), 32'd1);
      chk("e1_s2", smp(x1, x2, t), smp(7'sd0, 7'sd4, 2'sd1));
      step();
      chk("e1_end", 32'(epochEnd), 32'd1);
      chk("e1_v3", 32'(smpValid), 32'd0);
      chk("e1_data0", smp(x1, x2, t), 32'd0);
      chk("e1_epochCount", 32'(epochCount), 32'd1);
      chk("e1_count", sampleCount, 32'd3);
      step();
      chk("e1_endpulse", 32'(epochEnd), 32'd0);

      // Back-pressure 1,0,0,1
      start = 1'b1; step(); start = 1'b0;
      chk("bp_s0", smp(x1, x2, t), smp(7'sd5, -7'sd3, 2'sd1));
      step();
      smpReady = 1'b0;
      chk("bp_s1a", smp(x1, x2, t), smp(-7'sd7, 7'sd2, -2'sd1));
      step();
      chk("bp_s1b", smp(x1, x2, t), smp(-7'sd7, 7'sd2, -2'sd1));
      chk("bp_vb", 32'(smpValid), 32'd1);
      step();
      chk("bp_s1c", smp(x1, x2, t), smp(-7'sd7, 7'sd2, -2'sd1));
      smpReady = 1'b1;
      step();
      chk("bp_s2", smp(x1, x2, t), smp(7'sd0, 7'sd4, 2'sd1));
      chk("bp_noend", 32'(epochEnd), 32'd0);
      step();
      chk("bp_end", 32'(epochEnd), 32'd1);
      chk("bp_epochCount", 32'(epochCount), 32'd2);

      // Reset mid-epoch after one sample consumed
      start = 1'b1; step(); start = 1'b0;
      step();
      chk("rm_s1", smp(x1, x2, t), smp(-7'sd7, 7'sd2, -2'sd1));
      rst = 1'b1; step(); rst = 1'b0;
      chk("rm_smpValid", 32'(smpValid), 32'd0);
      chk("rm_epochEnd", 32'(epochEnd), 32'd0);
      chk("rm_wrReady", 32'(wrReady), 32'd1);
      chk("rm_count", sampleCount, 32'd0);
      chk("rm_epochCount", 32'(epochCount), 32'd0);

      // loadDone with nothing loaded, then start
      loadDone = 1'b1; step(); loadDone = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      chk("ld0_wrReady", 32'(wrReady), 32'd1);
      chk("ld0_smpValid", 32'(smpValid), 32'd0);
      step();
      chk("ld0_smpValid2", 32'(smpValid), 32'd0);

      // Fill to capacity, then offer an extra value 9
      for (int i = 0; i < DEPTH; i++) begin
         wr(7'(i + 1), 7'(-(i + 1)), (i % 2 == 0) ? 2'sd1 : -2'sd1);
      end
      chk("full_wrReady", 32'(wrReady), 32'd0);
      chk("full_count", sampleCount, 32'(DEPTH));
      wrValid = 1'b1; wrX1 = 7'sd9; wrX2 = 7'sd9; wrT = 2'sd1;
      step(); step();
      wrValid = 1'b0;
      chk("full_count2", sampleCount, 32'(DEPTH));
      chk("full_wrReady2", 32'(wrReady), 32'd0);
      loadDone = 1'b1; step(); loadDone = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         chk("full_v", 32'(smpValid), 32'd1);
         chk("full_s", smp(x1, x2, t), smp(7'(i + 1), 7'(-(i + 1)), (i % 2 == 0) ? 2'sd1 : -2'sd1));
         step();
      end
      chk("full_end", 32'(epochEnd), 32'd1);
      chk("full_epochCount", 32'(epochCount), 32'd1);

      // clear and start together in WAIT
      clear = 1'b1; start = 1'b1; step(); clear = 1'b0; start = 1'b0;
      chk("clr_wrReady", 32'(wrReady), 32'd1);
      chk("clr_count", sampleCount, 32'd0);
      chk("clr_epochCount", 32'(epochCount), 32'd0);
      chk("clr_smpValid", 32'(smpValid), 32'd0);
      step();
      chk("clr_smpValid2", 32'(smpValid), 32'd0);

      // Write coinciding with loadDone counts toward leaving LOAD
      wrValid = 1'b1; loadDone = 1'b1; wrX1 = -7'sd64; wrX2 = 7'sd63; wrT = -2'sd1;
      step();
      wrValid = 1'b0; loadDone = 1'b0;
      chk("sw_wrReady", 32'(wrReady), 32'd0);
      chk("sw_count", sampleCount, 32'd1);
      start = 1'b1; step(); start = 1'b0;
      chk("sw_s0", smp(x1, x2, t), smp(-7'sd64, 7'sd63, -2'sd1));
      step();
      chk("sw_end", 32'(epochEnd), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
